module_multiplicador_seq: RTL and testbench
===========================================

Name: module_multiplicador_seq

Overview:
Sequential shift-add multiplier that sits directly downstream of the keypad capture stage. It consumes the two captured operands (first_num, second_num) when the keypad's sequence-complete flag (ready) rises. It then produces their unsigned product after a fixed number of cycles. The result is held for the display stage, with a one-cycle completion pulse.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  reset, synchronous, active-high
first_num  input  WIDTH  multiplicand from keypad stage, unsigned binary
second_num  input  WIDTH  multiplier from keypad stage, unsigned binary
ready  input  1  keypad sequence-complete level; a rising edge requests a multiply
busy  output  1  high while a multiply is in progress (states LOAD..DONE)
product  output  2*WIDTH  last completed product, held until next completion
product_valid  output  1  one-cycle pulse when product updates

Behaviour:
- Reset (synchronous, active-high, sampled on clk rising edge): state=IDLE; product=0; product_valid=0; busy=0; internal accumulator, operand and counter registers=0.
- Reset: ready_q (edge-detect register) resets to 1, so a ready level held high across reset does not trigger a start.
- Start detect: start = ready & ~ready_q. ready_q <= ready every cycle in every state.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: busy=0. On start, go to LOAD. Otherwise stay.
- LOAD (1 cycle): latch A<=first_num, P<={WIDTH+1 zeros, second_num}, cnt<=0, then go to RUN. busy=1.
- RUN (exactly WIDTH cycles): each cycle, if P[0] then P[2W:W] <= P[2W:W] + A; then logical shift of the full (2W+1)-bit P right by 1. The carry bit P[2W] absorbs overflow. cnt increments; when cnt==WIDTH-1, go to DONE. busy=1.
- DONE (1 cycle): product <= P[2W-1:0]; product_valid=1 for this cycle only; busy=1; next state IDLE.
- Latency: if the ready rise is sampled at edge E0, product_valid is high in the cycle after edge E0+WIDTH+2, i.e. WIDTH+2 cycles after acceptance. For WIDTH=8 this is 10 cycles.
- Operands are sampled only in LOAD. Changes to first_num or second_num afterwards do not affect the result.
- A ready rise while busy is ignored and is not queued. Because ready_q keeps tracking, a ready still high on return to IDLE does not retrigger.
- Zero operand: the full WIDTH-cycle run still executes; product=0 and the valid pulse still occurs.
- Maximum operands (2^WIDTH-1)^2 must not overflow 2*WIDTH bits (0xFE01 for WIDTH=8).
- Reset asserted in any state aborts immediately and forces reset values; no valid pulse for the aborted operation.
- Outside DONE, product holds its value; product_valid=0.

Decomposition:
- Shared package mult_pkg: state enum type (IDLE, LOAD, RUN, DONE) and the default WIDTH constant. The display/top stage imports it for product width.
- Sub-module module_detector_flanco: rising-edge detector with registered previous value and parameterised reset value (1 here). This module instantiates it for ready.
- Datapath (A, P, cnt) and FSM stay in this module.

Test Plan:
- Reset held 20 cycles with ready=1, then released while ready stays 1 -> no start; busy=0, product=0, product_valid=0 throughout.
- first_num=12, second_num=34, ready 0->1 -> product=408 (0x0198); product_valid exactly one cycle, exactly 10 cycles after the ready rise is sampled; busy high for the 10 cycles before.
- first_num=255, second_num=255 -> product=65025 (0xFE01). first_num=0, second_num=200 -> product=0 with a valid pulse.
- During RUN, toggle ready 1->0->1 and change first_num to 99 -> only one valid pulse; product equals the originally latched operands' product.
- Assert rst for 1 cycle mid-RUN -> next cycle busy=0, product=0, no valid pulse. A subsequent new rise with 7*6 -> product=42.
- Back-to-back: ready falls after the first DONE and rises again in IDLE with 3*5 -> second valid pulse, product=15; the previous product is held until that pulse.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and default width for the keypad multiplier
package mult_pkg;

   // Default operand width; the product is twice this wide
   localparam int WIDTH_DEF = 8;

   // Multiplier control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/module_detector_flanco.sv
// rtl/module_detector_flanco.sv - registered rising-edge detector with programmable reset value
module module_detector_flanco #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic sig_q;

   // Previous-value register; resetting to 1 masks a level already high at reset release
   always_ff @(posedge clk) begin
      if (rst) sig_q <= RST_VAL;
      else     sig_q <= sig;
   end

   assign rise = sig & ~sig_q;

endmodule

// File: rtl/module_multiplicador_seq.sv
// rtl/module_multiplicador_seq.sv - shift-add sequential unsigned multiplier fed by the keypad stage
module module_multiplicador_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     first_num,
   input  logic [WIDTH-1:0]     second_num,
   input  logic                 ready,
   output logic                 busy,
   output logic [2*WIDTH-1:0]   product,
   output logic                 product_valid
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t             state, state_n;
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [2*WIDTH:0]   p;
   logic [2*WIDTH:0]   p_shift;
   logic [WIDTH:0]     upper_sum;
   logic [CW-1:0]      cnt;

   module_detector_flanco #(
      .RST_VAL (1'b1)
   ) u_ready_edge (
      .clk  (clk),
      .rst  (rst),
      .sig  (ready),
      .rise (start)
   );

   // One shift-add step: conditionally add the multiplicand into the upper half, then shift right
   always_comb begin
      upper_sum = p[2*WIDTH:WIDTH] + (p[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
      p_shift   = {1'b0, upper_sum, p[WIDTH-1:1]};
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state and busy decode; a rise seen outside IDLE is simply dropped
   always_comb begin
      state_n = state;
      busy    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_n = LOAD;
         end
         LOAD: begin
            busy    = 1'b1;
            state_n = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == CNT_LAST) state_n = DONE;
         end
         DONE: begin
            busy    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath: operands latched once in LOAD, product published from DONE with a one-cycle pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         a             <= '0;
         p             <= '0;
         cnt           <= '0;
         product       <= '0;
         product_valid <= 1'b0;
      end else begin
         product_valid <= 1'b0;
         case (state)
            LOAD: begin
               a   <= first_num;
               p   <= {{(WIDTH+1){1'b0}}, second_num};
               cnt <= '0;
            end
            RUN: begin
               p   <= p_shift;
               cnt <= cnt + 1'b1;
            end
            DONE: begin
               product       <= p[2*WIDTH-1:0];
               product_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_module_multiplicador_seq.sv
// tb/tb_module_multiplicador_seq.sv - scoreboard bench for the sequential multiplier
module tb_module_multiplicador_seq;
   import mult_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ready = 1'b1;
   logic [7:0]  first_num = 8'd0;
   logic [7:0]  second_num = 8'd0;
   logic        busy;
   logic [15:0] product;
   logic        product_valid;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int pulses = 0;

   typedef struct {
      logic [15:0] prod;
      int          acc;
   } exp_t;

   exp_t sb[$];

   module_multiplicador_seq #(.WIDTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .first_num     (first_num),
      .second_num    (second_num),
      .ready         (ready),
      .busy          (busy),
      .product       (product),
      .product_valid (product_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (product_valid === 1'b1) begin
         pulses++;
         if (sb.size() == 0) begin
            check("unexpected_pulse", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("product", product, e.prod);
            check("latency", cyc - e.acc, 10);
         end
      end
   end

   task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp, input bit push);
      exp_t e;
      @(negedge clk);
      first_num  = a;
      second_num = b;
      ready      = 1'b1;
      if (push) begin
         e.prod = exp;
         e.acc  = cyc + 1;
         sb.push_back(e);
      end
   endtask

   task automatic wait_idle();
      bit done_ok;
      done_ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            done_ok = 1'b1;
            break;
         end
      end
      if (!done_ok) check("timeout", 1, 0);
   endtask

   task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input logic [15:0] prev);
      int busy_err;
      int hold_err;
      busy_err = 0;
      hold_err = 0;
      start_op(a, b, exp, 1'b1);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         if (busy !== (i < 10)) busy_err++;
         if (i < 10 && product !== prev) hold_err++;
      end
      check({name, "_busy"}, busy_err, 0);
      check({name, "_hold"}, hold_err, 0);
      ready = 1'b0;
      wait_idle();
   endtask

   initial begin
      int err;
      int p0;

      // Reset held with ready high, released while ready stays high
      repeat (20) @(negedge clk);
      rst = 1'b0;
      err = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || product !== 16'd0 || product_valid !== 1'b0) err++;
      end
      check("reset_quiet", err, 0);
      check("reset_product", product, 0);
      check("reset_pulses", pulses, 0);

      @(negedge clk);
      ready = 1'b0;
      run_op("op12x34", 8'd12, 8'd34, 16'd408, 16'd0);
      run_op("op255x255", 8'd255, 8'd255, 16'hFE01, 16'd408);
      run_op("op0x200", 8'd0, 8'd200, 16'd0, 16'hFE01);

      // Ready toggled and first_num changed mid-run: one pulse, original operands
      p0 = pulses;
      start_op(8'd17, 8'd11, 16'd187, 1'b1);
      repeat (3) @(negedge clk);
      ready = 1'b0;
      @(negedge clk);
      ready     = 1'b1;
      first_num = 8'd99;
      wait_idle();
      repeat (15) @(negedge clk);
      check("toggle_pulses", pulses - p0, 1);
      check("toggle_product", product, 187);

      // Reset mid-run aborts without a pulse
      ready = 1'b0;
      p0 = pulses;
      start_op(8'd200, 8'd200, 16'd0, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_product", product, 0);
      repeat (15) @(negedge clk);
      check("abort_pulses", pulses - p0, 0);
      ready = 1'b0;
      @(negedge clk);
      run_op("op7x6", 8'd7, 8'd6, 16'd42, 16'd0);

      // Back-to-back: previous product held until the next pulse
      run_op("op3x5", 8'd3, 8'd5, 16'd15, 16'd42);

      repeat (5) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      check("pulse_count", pulses, 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
